// File: rtl/pipe_control_pkg.sv
// rtl/pipe_control_pkg.sv - shared opcodes, control-bit indices and ALUOp encodings
// Purpose: common definitions for the pipelined main-control unit.
// Ports: none (package).
package pipe_control_pkg;

  localparam int OP_W   = 6;
  localparam int CORE_W = 11;  // meaningful control-word bits; anything above is zero

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam int RW       = 0;
  localparam int M2R      = 1;
  localparam int MW       = 2;
  localparam int MR       = 3;
  localparam int RDST     = 4;
  localparam int ALUOP_LO = 5;   // occupies [6:5]
  localparam int ALUSRC   = 7;
  localparam int LINK     = 8;
  localparam int ZEXT     = 9;
  localparam int ALUOP_HI = 10;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_SLT   = 3'b110
  } aluop_e;

  typedef struct packed {
    logic branch;
    logic bne;
    logic jump;
    logic link;
  } strobe_t;

  // ALUOp is split across the word: bit 2 lives at [10], bits 1:0 at [6:5].
  function automatic logic [CORE_W-1:0] aluop_bits(input aluop_e op);
    logic [2:0] a;
    logic [CORE_W-1:0] w;
    a = op;
    w = '0;
    w[ALUOP_HI] = a[2];
    w[ALUOP_LO +: 2] = a[1:0];
    return w;
  endfunction

endpackage

// File: rtl/pipe_control_if.sv
// rtl/pipe_control_if.sv - ID-stage inputs and pipelined control outputs of pipe_control
// Purpose: bundles the decode/hazard inputs and the control-register outputs.
// Signals: op_i, valid_i, stall_i, flush_i, hold_i (to the unit);
//          ex/mem/wb_ctrl_o, branch/bne/jump/link_o, illegal_o, bubble_cnt_o (from the unit).
// Modports: master = pipeline side driving the unit, slave = pipe_control.
interface pipe_control_if
  import pipe_control_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 16
) ();

  logic [OP_W-1:0]   op_i;
  logic              valid_i;
  logic              stall_i;
  logic              flush_i;
  logic              hold_i;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CTRL_W-1:0] mem_ctrl_o;
  logic [CTRL_W-1:0] wb_ctrl_o;
  logic              branch_o;
  logic              bne_o;
  logic              jump_o;
  logic              link_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output op_i, valid_i, stall_i, flush_i, hold_i,
    input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o,
    input  branch_o, bne_o, jump_o, link_o, illegal_o, bubble_cnt_o
  );

  modport slave (
    input  op_i, valid_i, stall_i, flush_i, hold_i,
    output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o,
    output branch_o, bne_o, jump_o, link_o, illegal_o, bubble_cnt_o
  );

endinterface

// File: rtl/pipe_control_ctrl_decode.sv
// rtl/pipe_control_ctrl_decode.sv - combinational opcode to control-word decoder
// Purpose: raw decode of the ID opcode; qualification by valid/hazards happens in the top.
// Ports: op_i (opcode) -> word_o (11-bit control word), strobe_o (branch/bne/jump/link),
//        illegal_o (opcode not recognised for this EXT_OPS setting).
module ctrl_decode
  import pipe_control_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [OP_W-1:0]   op_i,
  output logic [CORE_W-1:0] word_o,
  output strobe_t           strobe_o,
  output logic              illegal_o
);

  always_comb begin
    word_o    = '0;
    strobe_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        word_o[RW]   = 1'b1;
        word_o[RDST] = 1'b1;
        word_o       = word_o | aluop_bits(ALU_FUNCT);
      end
      OP_LW: begin
        word_o[RW]     = 1'b1;
        word_o[M2R]    = 1'b1;
        word_o[MR]     = 1'b1;
        word_o[ALUSRC] = 1'b1;
      end
      OP_SW: begin
        word_o[MW]     = 1'b1;
        word_o[ALUSRC] = 1'b1;
      end
      OP_ADDI: begin
        word_o[RW]     = 1'b1;
        word_o[ALUSRC] = 1'b1;
      end
      OP_BEQ: strobe_o.branch = 1'b1;
      OP_J:   strobe_o.jump   = 1'b1;
      OP_ANDI: begin
        if (EXT_OPS != 0) begin
          word_o[RW]     = 1'b1;
          word_o[ALUSRC] = 1'b1;
          word_o[ZEXT]   = 1'b1;
          word_o         = word_o | aluop_bits(ALU_AND);
        end else illegal_o = 1'b1;
      end
      OP_ORI: begin
        if (EXT_OPS != 0) begin
          word_o[RW]     = 1'b1;
          word_o[ALUSRC] = 1'b1;
          word_o[ZEXT]   = 1'b1;
          word_o         = word_o | aluop_bits(ALU_OR);
        end else illegal_o = 1'b1;
      end
      OP_SLTI: begin
        if (EXT_OPS != 0) begin
          word_o[RW]     = 1'b1;
          word_o[ALUSRC] = 1'b1;
          word_o         = word_o | aluop_bits(ALU_SLT);
        end else illegal_o = 1'b1;
      end
      OP_BNE: begin
        if (EXT_OPS != 0) strobe_o.bne = 1'b1;
        else illegal_o = 1'b1;
      end
      OP_JAL: begin
        if (EXT_OPS != 0) begin
          word_o[RW]    = 1'b1;
          word_o[LINK]  = 1'b1;
          strobe_o.jump = 1'b1;
          strobe_o.link = 1'b1;
        end else illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - pipelined main control with stall bubbles, flush squash and hold
// Purpose: decodes the ID opcode and carries the control word through ID/EX, EX/MEM, MEM/WB.
// Ports: clk_i, rst_i (async, active-high); bus (pipe_control_if.slave) carries
//        op/valid/stall/flush/hold in and the three control registers, ID strobes,
//        sticky illegal flag and saturating bubble count out.
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int CTRL_W  = 32,
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pipe_control_if.slave  bus
);

  logic [CORE_W-1:0] dec_word;
  strobe_t           dec_strobe;
  logic              dec_illegal;

  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_ctrl_decode (
    .op_i      (bus.op_i),
    .word_o    (dec_word),
    .strobe_o  (dec_strobe),
    .illegal_o (dec_illegal)
  );

  // An instruction actually issues from ID only when nothing squashes or freezes it.
  logic issue;
  assign issue = bus.valid_i & ~bus.flush_i & ~bus.stall_i & ~bus.hold_i;

  assign bus.branch_o = dec_strobe.branch & issue;
  assign bus.bne_o    = dec_strobe.bne    & issue;
  assign bus.jump_o   = dec_strobe.jump   & issue;
  assign bus.link_o   = dec_strobe.link   & issue;

  logic [CTRL_W-1:0] ex_q, mem_q, wb_q, ex_d;
  logic              illegal_q;
  logic [CNT_W-1:0]  cnt_q;

  // Hold wins over everything; otherwise any reason not to issue inserts a bubble.
  always_comb begin
    ex_d = ex_q;
    if (!bus.hold_i) begin
      if (bus.flush_i || bus.stall_i || !bus.valid_i) ex_d = '0;
      else ex_d = CTRL_W'(dec_word);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_q <= ex_d;
      if (!bus.hold_i) begin
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      if (issue && dec_illegal) illegal_q <= 1'b1;
      // A stall coinciding with a flush is still one bubble, counted once.
      if (bus.stall_i && !bus.hold_i && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_ctrl_o    = ex_q;
  assign bus.mem_ctrl_o   = mem_q;
  assign bus.wb_ctrl_o    = wb_q;
  assign bus.illegal_o    = illegal_q;
  assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - table-driven self-checking bench for pipe_control
module tb_pipe_control;
  import pipe_control_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = '0;
  logic valid = 1'b0, stall = 1'b0, flush = 1'b0, hold = 1'b0;

  always #5 clk = ~clk;

  pipe_control_if #(.CTRL_W(32), .CNT_W(16)) if_a ();
  pipe_control_if #(.CTRL_W(32), .CNT_W(16)) if_b ();
  pipe_control_if #(.CTRL_W(32), .CNT_W(2))  if_c ();

  assign if_a.op_i = op;  assign if_a.valid_i = valid; assign if_a.stall_i = stall;
  assign if_a.flush_i = flush; assign if_a.hold_i = hold;
  assign if_b.op_i = op;  assign if_b.valid_i = valid; assign if_b.stall_i = stall;
  assign if_b.flush_i = flush; assign if_b.hold_i = hold;
  assign if_c.op_i = op;  assign if_c.valid_i = valid; assign if_c.stall_i = stall;
  assign if_c.flush_i = flush; assign if_c.hold_i = hold;

  pipe_control #(.CTRL_W(32), .EXT_OPS(1), .CNT_W(16)) dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  pipe_control #(.CTRL_W(32), .EXT_OPS(0), .CNT_W(16)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
  pipe_control #(.CTRL_W(32), .EXT_OPS(1), .CNT_W(2))  dut_c (.clk_i(clk), .rst_i(rst), .bus(if_c));

  typedef struct {
    logic [5:0]  op;
    logic        v, s, f, h;
    logic [3:0]  str;   // {branch, bne, jump, link}
    logic [31:0] ex, mem, wb;
    int          cnt;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic v, input logic s, input logic f,
                     input logic h, input logic [3:0] str, input logic [31:0] ex,
                     input logic [31:0] mem, input logic [31:0] wb, input int cnt,
                     input logic ill);
    vec_t t;
    t.op = o; t.v = v; t.s = s; t.f = f; t.h = h; t.str = str;
    t.ex = ex; t.mem = mem; t.wb = wb; t.cnt = cnt; t.ill = ill;
    vecs.push_back(t);
  endtask

  function automatic logic [3:0] strobes_a();
    return {if_a.branch_o, if_a.bne_o, if_a.jump_o, if_a.link_o};
  endfunction

  initial begin
    //   op         v  s  f  h  str      ex          mem         wb          cnt ill
    add(OP_RTYPE, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h0,      0, 0);
    add(OP_LW,    1, 0, 0, 0, 4'b0000, 32'h8B,     32'h0,      32'h0,      0, 0);
    add(OP_RTYPE, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h8B,     32'h0,      0, 0);
    add(OP_RTYPE, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h8B,     0, 0);
    add(OP_RTYPE, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h0,      0, 0);
    add(OP_ORI,   1, 0, 0, 0, 4'b0000, 32'h6A1,    32'h0,      32'h0,      0, 0);
    add(OP_ADDI,  1, 0, 0, 0, 4'b0000, 32'h81,     32'h6A1,    32'h0,      0, 0);
    add(OP_ADDI,  1, 1, 0, 0, 4'b0000, 32'h0,      32'h81,     32'h6A1,    1, 0);
    add(OP_ADDI,  1, 1, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h81,     2, 0);
    add(OP_SW,    1, 0, 0, 0, 4'b0000, 32'h84,     32'h0,      32'h0,      2, 0);
    add(OP_BEQ,   1, 0, 1, 0, 4'b0000, 32'h0,      32'h84,     32'h0,      2, 0);
    add(OP_BEQ,   1, 0, 0, 0, 4'b1000, 32'h0,      32'h0,      32'h84,     2, 0);
    add(OP_ANDI,  1, 0, 0, 0, 4'b0000, 32'h681,    32'h0,      32'h0,      2, 0);
    add(OP_SLTI,  1, 0, 0, 0, 4'b0000, 32'h4C1,    32'h681,    32'h0,      2, 0);
    add(OP_RTYPE, 1, 0, 0, 0, 4'b0000, 32'h51,     32'h4C1,    32'h681,    2, 0);
    add(OP_JAL,   1, 0, 0, 1, 4'b0000, 32'h51,     32'h4C1,    32'h681,    2, 0);
    add(OP_JAL,   1, 1, 0, 1, 4'b0000, 32'h51,     32'h4C1,    32'h681,    2, 0);
    add(OP_JAL,   1, 0, 0, 1, 4'b0000, 32'h51,     32'h4C1,    32'h681,    2, 0);
    add(OP_RTYPE, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h51,     32'h4C1,    2, 0);
    add(OP_RTYPE, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h51,     2, 0);
    add(OP_JAL,   1, 0, 0, 0, 4'b0011, 32'h101,    32'h0,      32'h0,      2, 0);
    add(OP_BNE,   1, 0, 0, 0, 4'b0100, 32'h0,      32'h101,    32'h0,      2, 0);
    add(OP_J,     1, 0, 0, 0, 4'b0010, 32'h0,      32'h0,      32'h101,    2, 0);
    add(OP_LW,    1, 1, 1, 0, 4'b0000, 32'h0,      32'h0,      32'h0,      3, 0);
    add(6'h3F,    0, 0, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h0,      3, 0);
    add(6'h3F,    1, 1, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h0,      4, 0);
    add(6'h3F,    1, 0, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h0,      4, 1);
    add(OP_RTYPE, 0, 0, 0, 0, 4'b0000, 32'h0,      32'h0,      32'h0,      4, 1);

    // Reset state.
    #1;
    chk("rst_ex",  if_a.ex_ctrl_o,  32'h0);
    chk("rst_mem", if_a.mem_ctrl_o, 32'h0);
    chk("rst_wb",  if_a.wb_ctrl_o,  32'h0);
    chk("rst_ill", 32'(if_a.illegal_o), 32'h0);
    chk("rst_cnt", 32'(if_a.bubble_cnt_o), 32'h0);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      op = vecs[i].op; valid = vecs[i].v; stall = vecs[i].s;
      flush = vecs[i].f; hold = vecs[i].h;
      #1;
      chk($sformatf("v%0d_strobes", i), 32'(strobes_a()), 32'(vecs[i].str));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex", i),  if_a.ex_ctrl_o,  vecs[i].ex);
      chk($sformatf("v%0d_mem", i), if_a.mem_ctrl_o, vecs[i].mem);
      chk($sformatf("v%0d_wb", i),  if_a.wb_ctrl_o,  vecs[i].wb);
      chk($sformatf("v%0d_cnt", i), 32'(if_a.bubble_cnt_o), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_ill", i), 32'(if_a.illegal_o), 32'(vecs[i].ill));
    end

    // Mid-stream asynchronous reset between edges.
    op = OP_LW; valid = 1'b1; stall = 1'b0; flush = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    op = OP_ADDI;
    @(posedge clk); #1;
    chk("pre_rst_ex",  if_a.ex_ctrl_o,  32'h81);
    chk("pre_rst_mem", if_a.mem_ctrl_o, 32'h8B);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ex",  if_a.ex_ctrl_o,  32'h0);
    chk("mid_rst_mem", if_a.mem_ctrl_o, 32'h0);
    chk("mid_rst_ill", 32'(if_a.illegal_o), 32'h0);
    chk("mid_rst_cnt", 32'(if_a.bubble_cnt_o), 32'h0);
    op = OP_BEQ;
    #1;
    chk("rst_branch_strobe", 32'(if_a.branch_o), 32'h1);
    op = OP_RTYPE;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ex", if_a.ex_ctrl_o, 32'h51);

    // EXT_OPS=0 treats ori/bne as illegal; the flag is sticky until reset.
    op = OP_ORI;
    @(posedge clk); #1;
    chk("b_ori_ex",  if_b.ex_ctrl_o, 32'h0);
    chk("b_ori_ill", 32'(if_b.illegal_o), 32'h1);
    chk("a_ori_ex",  if_a.ex_ctrl_o, 32'h6A1);
    op = OP_BNE;
    #1;
    chk("b_bne_strobe", 32'(if_b.bne_o), 32'h0);
    chk("a_bne_strobe", 32'(if_a.bne_o), 32'h1);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b_ill_sticky", 32'(if_b.illegal_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("b_ill_cleared", 32'(if_b.illegal_o), 32'h0);
    #1 rst = 1'b0;

    // Five stalls saturate a 2-bit bubble counter at 3.
    stall = 1'b1;
    repeat (5) @(posedge clk);
    #1 stall = 1'b0;
    chk("c_cnt_sat", 32'(if_c.bubble_cnt_o), 32'h3);
    chk("a_cnt_5",   32'(if_a.bubble_cnt_o), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
